// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// Holds the FSM state encoding, bus widths and the byte-lane merge used on stores.
package dmem_pkg;

    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    // Merge new_word into old_word, replacing only the byte lanes whose enable is set.
    function automatic logic [DATA_W-1:0] be_merge(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [BE_W-1:0]   be
    );
        logic [DATA_W-1:0] merged;
        merged = old_word;
        for (int i = 0; i < BE_W; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                merged[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage behind the responder: 2**ADDR_W x 32 bits.
// One access port: a synchronous byte-enable write and a registered read.
// The read register can be forced to zero so that store and error responses
// return 0 without an extra pipeline stage. The storage itself has no reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              acc_en,
    input  logic              wr_en,
    input  logic              rd_zero,
    input  logic [ADDR_W-1:0] idx,
    input  logic [DATA_W-1:0] wdata,
    input  logic [BE_W-1:0]   be,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_r [0:DEPTH-1];
    logic [DATA_W-1:0] rdata_r;

    // Byte-lane write into the array; contents survive reset on purpose.
    always_ff @(posedge clk) begin
        if (acc_en && wr_en) begin
            mem_r[idx] <= be_merge(mem_r[idx], wdata, be);
        end
    end

    // Registered read data, held between accesses and cleared by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_r <= {DATA_W{1'b0}};
        end else if (acc_en) begin
            if (rd_zero) begin
                rdata_r <= {DATA_W{1'b0}};
            end else begin
                rdata_r <= mem_r[idx];
            end
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the core data bus.
// Accepts one request at a time (req_valid/req_ready), waits WAIT cycles,
// performs the array access and presents the result (rsp_valid/rsp_ready).
// Optional build macro DMEM_ERR_EN: addresses with non-zero bits above the
// array range are flagged with rsp_err and never written; without it those
// bits are ignored and addresses alias onto the array.
module dmem_responder #(
    parameter int ADDR_W = 12,
    parameter int WAIT   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    // The state literal WAIT is always written package-qualified because the
    // module parameter of the same name takes precedence inside this scope.
    import dmem_pkg::*;

    localparam bit         HAS_WAIT  = (WAIT > 0);
    localparam logic [3:0] WAIT_INIT = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

    dmem_state_t       state_r, state_s;
    logic [3:0]        cnt_r, cnt_s;
    logic              rsp_valid_r, rsp_valid_s;
    logic              rsp_err_r;
    logic              cap_s;
    logic              acc_s;

    logic              we_r;
    logic [ADDR_W-1:0] idx_r;
    logic [31:0]       wdata_r;
    logic [3:0]        be_r;
    logic              oob_r;

    logic              req_oob_s;
    logic              unused_addr_s;

    logic              acc_we_s;
    logic              acc_oob_s;
    logic [ADDR_W-1:0] acc_idx_s;
    logic [31:0]       acc_wdata_s;
    logic [3:0]        acc_be_s;
    logic [31:0]       arr_rdata_s;

`ifdef DMEM_ERR_EN
    assign req_oob_s     = (req_addr[31:ADDR_W+2] != {(30-ADDR_W){1'b0}});
    assign unused_addr_s = ^req_addr[1:0];
`else
    assign req_oob_s     = 1'b0;
    assign unused_addr_s = ^{req_addr[31:ADDR_W+2], req_addr[1:0]};
`endif

    // Next-state, counter and access-strobe decode for the request FSM.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        rsp_valid_s = rsp_valid_r;
        cap_s       = 1'b0;
        acc_s       = 1'b0;
        case (state_r)
            dmem_pkg::IDLE: begin
                if (req_valid) begin
                    cap_s = 1'b1;
                    if (HAS_WAIT) begin
                        state_s = dmem_pkg::WAIT;
                        cnt_s   = WAIT_INIT;
                    end else begin
                        state_s     = dmem_pkg::RESP;
                        acc_s       = 1'b1;
                        rsp_valid_s = 1'b1;
                    end
                end else begin
                    state_s = dmem_pkg::IDLE;
                end
            end
            dmem_pkg::WAIT: begin
                if (cnt_r == 4'd0) begin
                    state_s     = dmem_pkg::RESP;
                    acc_s       = 1'b1;
                    rsp_valid_s = 1'b1;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            dmem_pkg::RESP: begin
                if (rsp_ready) begin
                    state_s     = dmem_pkg::IDLE;
                    rsp_valid_s = 1'b0;
                end else begin
                    state_s = dmem_pkg::RESP;
                end
            end
            default: begin
                state_s     = dmem_pkg::IDLE;
                cnt_s       = 4'd0;
                rsp_valid_s = 1'b0;
            end
        endcase
    end

    // Access operands: straight from the bus when a zero-wait accept accesses
    // on the accept edge, otherwise from the captured request.
    always_comb begin
        acc_we_s    = 1'b0;
        acc_oob_s   = 1'b0;
        acc_idx_s   = {ADDR_W{1'b0}};
        acc_wdata_s = 32'd0;
        acc_be_s    = 4'd0;
        if (state_r == dmem_pkg::IDLE) begin
            acc_we_s    = req_we;
            acc_oob_s   = req_oob_s;
            acc_idx_s   = req_addr[ADDR_W+1:2];
            acc_wdata_s = req_wdata;
            acc_be_s    = req_be;
        end else begin
            acc_we_s    = we_r;
            acc_oob_s   = oob_r;
            acc_idx_s   = idx_r;
            acc_wdata_s = wdata_r;
            acc_be_s    = be_r;
        end
    end

    // FSM state, wait counter and response-valid registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= dmem_pkg::IDLE;
            cnt_r       <= 4'd0;
            rsp_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            rsp_valid_r <= rsp_valid_s;
        end
    end

    // Capture the request fields on accept; they stay frozen until the next one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_r    <= 1'b0;
            idx_r   <= {ADDR_W{1'b0}};
            wdata_r <= 32'd0;
            be_r    <= 4'd0;
            oob_r   <= 1'b0;
        end else if (cap_s) begin
            we_r    <= req_we;
            idx_r   <= req_addr[ADDR_W+1:2];
            wdata_r <= req_wdata;
            be_r    <= req_be;
            oob_r   <= req_oob_s;
        end
    end

    // Error flag is set with the access and dropped after the response handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_err_r <= 1'b0;
        end else if (acc_s) begin
            rsp_err_r <= acc_oob_s;
        end else if ((state_r == dmem_pkg::RESP) && rsp_ready) begin
            rsp_err_r <= 1'b0;
        end
    end

    dmem_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .acc_en  (acc_s),
        .wr_en   (acc_we_s & ~acc_oob_s),
        .rd_zero (acc_we_s | acc_oob_s),
        .idx     (acc_idx_s),
        .wdata   (acc_wdata_s),
        .be      (acc_be_s),
        .rdata   (arr_rdata_s)
    );

    assign req_ready = (state_r == dmem_pkg::IDLE);
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = arr_rdata_s;
    assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a WAIT=1 instance carries most traffic,
// a WAIT=0 instance covers the zero-wait path. Expected responses come from a
// bench-side memory model and are queued when each request is driven.
module tb_dmem_responder;

`ifdef DMEM_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif
    localparam int WAIT_T = 1;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
    logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
    logic [3:0]  req_be = 4'd0;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    logic        z_req_valid = 1'b0, z_req_we = 1'b0, z_rsp_ready = 1'b0;
    logic [31:0] z_req_addr = 32'd0, z_req_wdata = 32'd0;
    logic [3:0]  z_req_be = 4'd0;
    logic        z_req_ready, z_rsp_valid, z_rsp_err;
    logic [31:0] z_rsp_rdata;

    exp_t        sb_q[$];
    logic [31:0] mdl  [0:4095];
    logic [31:0] mdl0 [0:4095];
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_W(12), .WAIT(WAIT_T)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    dmem_responder #(.ADDR_W(12), .WAIT(0)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
        .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_be(z_req_be),
        .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready),
        .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    // Model the request and queue its expected response.
    task automatic sb_push(input bit sel0, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be);
        exp_t        e;
        logic [11:0] w;
        logic        oob;
        logic [31:0] cur;
        w   = addr[13:2];
        oob = ERR_EN && (addr[31:14] != 18'd0);
        cur = sel0 ? mdl0[w] : mdl[w];
        e.err   = oob;
        e.rdata = (we || oob) ? 32'd0 : cur;
        if (we && !oob) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) cur[8*i +: 8] = wdata[8*i +: 8];
            end
            if (sel0) mdl0[w] = cur;
            else      mdl[w]  = cur;
        end
        sb_q.push_back(e);
    endtask

    task automatic sb_pop(input string name, output exp_t e);
        if (sb_q.size() == 0) begin
            check_eq({name, "_sb_nonempty"}, 32'd0, 32'd1);
            e.rdata = 32'hxxxx_xxxx;
            e.err   = 1'bx;
        end else begin
            e = sb_q.pop_front();
        end
    endtask

    // One full transaction on the WAIT=1 instance, with `hold` cycles of backpressure.
    task automatic do_req(input string name, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be, input int hold);
        exp_t e;
        int   k;
        check_eq({name, "_req_ready"}, 32'(req_ready), 32'd1);
        sb_push(1'b0, we, addr, wdata, be);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = 1'b0; req_wdata = 32'd0; req_be = 4'd0;
        k = 1;
        while (rsp_valid !== 1'b1 && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        check_eq({name, "_latency"}, 32'(k), 32'(WAIT_T + 1));
        check_eq({name, "_busy"}, 32'(req_ready), 32'd0);
        sb_pop(name, e);
        check_eq({name, "_rdata"}, rsp_rdata, e.rdata);
        check_eq({name, "_err"}, 32'(rsp_err), 32'(e.err));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check_eq({name, "_hold_valid"}, 32'(rsp_valid), 32'd1);
            check_eq({name, "_hold_rdata"}, rsp_rdata, e.rdata);
            check_eq({name, "_hold_ready"}, 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check_eq({name, "_done_valid"}, 32'(rsp_valid), 32'd0);
        check_eq({name, "_done_idle"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        exp_t e;
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_req_ready", 32'(req_ready), 32'd1);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_rsp_rdata", rsp_rdata, 32'd0);
        check_eq("rst_rsp_err", 32'(rsp_err), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Basic store then load
        do_req("t1_st", 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0);
        do_req("t1_ld", 1'b0, 32'h0000_0010, 32'd0, 4'h0, 0);

        // Byte lanes, including a store with no lanes enabled
        do_req("t2_st_full", 1'b1, 32'h0000_0030, 32'h1122_3344, 4'hF, 0);
        do_req("t2_st_part", 1'b1, 32'h0000_0030, 32'hAABB_CCDD, 4'b0101, 0);
        do_req("t2_ld", 1'b0, 32'h0000_0033, 32'd0, 4'h0, 0);
        check_eq("t2_model", mdl[12], 32'h11BB_33DD);
        do_req("t2_st_none", 1'b1, 32'h0000_0030, 32'hFFFF_FFFF, 4'b0000, 0);
        do_req("t2_ld_again", 1'b0, 32'h0000_0030, 32'd0, 4'h0, 0);

        // Backpressure during RESP
        do_req("t3_bp", 1'b0, 32'h0000_0010, 32'd0, 4'h0, 5);

        // Zero-wait instance: response the cycle after accept
        for (int it = 0; it < 2; it++) begin
            logic we_i;
            we_i = (it == 0);
            check_eq("t4_ready_n", 32'(z_req_ready), 32'd1);
            sb_push(1'b1, we_i, 32'h0000_0040, 32'hCAFE_F00D, 4'hF);
            z_req_valid = 1'b1; z_req_we = we_i; z_req_addr = 32'h0000_0040;
            z_req_wdata = 32'hCAFE_F00D; z_req_be = 4'hF;
            @(posedge clk); #1;
            z_req_valid = 1'b0; z_req_we = 1'b0;
            check_eq("t4_valid_n1", 32'(z_rsp_valid), 32'd1);
            check_eq("t4_ready_n1", 32'(z_req_ready), 32'd0);
            sb_pop("t4", e);
            check_eq("t4_rdata", z_rsp_rdata, e.rdata);
            check_eq("t4_err", 32'(z_rsp_err), 32'(e.err));
            z_rsp_ready = 1'b1;
            @(posedge clk); #1;
            z_rsp_ready = 1'b0;
            check_eq("t4_ready_n2", 32'(z_req_ready), 32'd1);
            check_eq("t4_valid_n2", 32'(z_rsp_valid), 32'd0);
        end

        // Reset while a store waits: the store must be dropped
        do_req("t5_st_prior", 1'b1, 32'h0000_0020, 32'h1234_5678, 4'hF, 0);
        do_req("t5_ld_prior", 1'b0, 32'h0000_0020, 32'd0, 4'h0, 0);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0000_0020;
        req_wdata = 32'h0000_0055; req_be = 4'hF;
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = 1'b0;
        check_eq("t5_in_wait", 32'(req_ready), 32'd0);
        rst = 1'b0;
        #1;
        check_eq("t5_rst_ready", 32'(req_ready), 32'd1);
        check_eq("t5_rst_valid", 32'(rsp_valid), 32'd0);
        check_eq("t5_rst_rdata", rsp_rdata, 32'd0);
        check_eq("t5_rst_err", 32'(rsp_err), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        do_req("t5_ld_after", 1'b0, 32'h0000_0020, 32'd0, 4'h0, 0);

        // Out-of-range store: flagged with the macro, aliases without it
        do_req("t6_st_base", 1'b1, 32'h0000_0000, 32'hA5A5_A5A5, 4'hF, 0);
        do_req("t6_st_high", 1'b1, 32'h0001_0000, 32'h0BAD_F00D, 4'hF, 0);
        do_req("t6_ld_base", 1'b0, 32'h0000_0000, 32'd0, 4'h0, 0);

        check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the core's data bus; the core is the initiator.
- Accepts one load/store request at a time over a valid/ready handshake, stalls for a programmable number of wait states, then returns a response over a second valid/ready handshake.
- Backed by an internal word array with byte-lane writes.
- Replaces the bare data RAM behind the core's aluout/writedata/memwrite path so that multi-cycle memory timing can be exercised.

Parameters:
- ADDR_W, 12, word-address width; the array holds 2**ADDR_W 32-bit words.
- WAIT, 1, wait states between accept and memory access; legal range 0..15.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- req_valid  input  1  the initiator presents a request.
- req_ready  output  1  the responder can accept a request; high only in IDLE.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address; bits [1:0] are ignored.
- req_wdata  input  32  store data.
- req_be  input  4  store byte enables; bit i enables byte lane [8i+7:8i].
- rsp_valid  output  1  response available.
- rsp_ready  input  1  the initiator takes the response.
- rsp_rdata  output  32  load data; 0 for store responses.
- rsp_err  output  1  address error flag; tied 0 unless DMEM_ERR_EN is defined.

Behaviour:
- Reset (rst=0, asynchronous):
  - state = IDLE, wait counter = 0.
  - Outputs: rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=1.
  - Array contents are not reset.
- States: IDLE, WAIT, RESP.
- IDLE:
  - Accept occurs on an edge with req_valid & req_ready.
  - On accept, register we, word index req_addr[ADDR_W+1:2], wdata and be.
  - Next state is WAIT with counter = WAIT-1 if WAIT>0; otherwise go straight to the access step.
- WAIT:
  - Counter decrements each cycle.
  - When counter == 0, perform the access on that edge and enter RESP.
- Access (on the edge entering RESP):
  - Load: rsp_rdata <= array[index].
  - Store: only the lanes enabled by be are written; rsp_rdata <= 0.
  - be = 4'b0000 on a store: no write occurs, but the response is still issued.
- Latency: rsp_valid rises WAIT+1 cycles after the accept edge.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err are held stable until rsp_valid & rsp_ready.
  - On that handshake edge: rsp_valid <= 0 and state <= IDLE.
  - req_ready goes high the following cycle, so no same-cycle back-to-back accept is possible.
- req_ready = (state == IDLE), derived combinationally from the state register.
- A load following a store to the same word returns the post-store merged word (no forwarding is needed because the responder is single-outstanding).
- Request inputs are ignored while not in IDLE.
- Reset mid-operation:
  - A pending request is dropped.
  - A store not yet performed (still in WAIT) is never written.
  - A store already performed (state RESP) remains in the array.

Optional Feature:
- Macro: DMEM_ERR_EN.
- Defined:
  - If req_addr[31:ADDR_W+2] != 0, the request is treated as out of range.
  - Out-of-range store: no array write.
  - Out-of-range load or store: rsp_rdata=0 and rsp_err=1.
  - Timing is identical to an in-range access.
- Not defined:
  - Upper address bits are ignored, so addresses alias modulo 2**(ADDR_W+2) bytes.
  - rsp_err is constant 0.

Decomposition:
- Package dmem_pkg contains:
  - state enum dmem_state_t {IDLE, WAIT, RESP};
  - localparam DATA_W=32 and BE_W=4;
  - function be_merge(old, new, be) returning the byte-lane merged word.
- Sub-module dmem_array holds the 2**ADDR_W x 32 storage with a synchronous byte-enable write and a registered read. dmem_responder instantiates it and owns the FSM and the wait counter.

Test Plan:
1. WAIT=1. Store addr=0x10, wdata=0xDEADBEEF, be=4'hF; then load addr=0x10. Required: rsp_valid 2 cycles after each accept; load returns 0xDEADBEEF; store returns rdata=0.
2. Byte lanes. Store 0x11223344 with be=4'hF, then store 0xAABBCCDD with be=4'b0101 to the same word; then load. Required: 0x11BB33DD.
3. Backpressure. Hold rsp_ready=0 for 5 cycles during RESP. Required: rsp_valid and rsp_rdata stable, req_ready=0 throughout; IDLE is reached on the cycle after rsp_ready=1.
4. WAIT=0 build. Load accepted at cycle N. Required: rsp_valid=1 at cycle N+1; req_ready=0 at N+1 and 1 at N+2 after the response handshake.
5. Reset mid-operation. Assert rst=0 while in WAIT during a store of 0x55 to addr 0x20, release, then load addr 0x20. Required:
   - outputs clear immediately on reset;
   - the load returns the prior contents of addr 0x20, not the interrupted store data (0x55).
6. DMEM_ERR_EN, ADDR_W=12. Store to addr=0x0001_0000, then load addr=0x0. Required: the store responds with rsp_err=1, and the previously stored word at addr 0x0 is unchanged. Without the macro, the same sequence aliases: the load returns the stored data and rsp_err=0.
